// File: rtl/cnn_stream_loader.sv
// ---------------------------------------------------------------------------
// cnn_stream_loader
//
// Host-side writer for the binary-CNN core load interface. A byte-wide
// valid/ready command stream is parsed into full image words and kernel
// entries. Each completed frame is presented on the output registers together
// with a one-cycle load strobe.
//
// Frame formats (one byte per accepted beat):
//    0x01, 98 payload bytes                 -> image load
//    0x02, addr, 4 kernel bytes, value       -> kernel load
// Any other command byte sets the sticky cmd_err flag and is dropped.
//
// Ports
//    clk           rising-edge clock
//    rst           asynchronous, active-high reset
//    s_data        stream byte
//    s_valid       s_data valid
//    s_ready       byte accepted when s_valid & s_ready
//    image         assembled image, bit i = stream bit i, LSB-first per byte
//    image_addr    image slot index for this load (auto-incrementing)
//    image_in_en   one-cycle strobe: image / image_addr valid
//    kernel        assembled binary kernel, LSB-first
//    kernel_value  kernel offset / threshold value
//    kernel_addr   kernel memory index
//    kernel_in_en  one-cycle strobe: kernel / kernel_value / kernel_addr valid
//    cmd_err       sticky unknown-command flag, cleared only by rst
// ---------------------------------------------------------------------------
module cnn_stream_loader #(
   parameter int BW       = 8,
   parameter int IMG_BITS = 784,
   parameter int KER_BITS = 25,
   parameter int IADDR_W  = 11,
   parameter int KADDR_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BW-1:0]       s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [IMG_BITS-1:0] image,
   output logic [IADDR_W-1:0]  image_addr,
   output logic                image_in_en,
   output logic [KER_BITS-1:0] kernel,
   output logic [BW-1:0]       kernel_value,
   output logic [KADDR_W-1:0]  kernel_addr,
   output logic                kernel_in_en,
   output logic                cmd_err
);

   localparam int IMG_BYTES = (IMG_BITS + BW - 1) / BW;
   localparam int KER_BYTES = (KER_BITS + BW - 1) / BW;
   localparam int MAX_BYTES = (IMG_BYTES > KER_BYTES) ? IMG_BYTES : KER_BYTES;
   localparam int CNT_W     = $clog2(MAX_BYTES);
   localparam int IMG_IW    = $clog2(IMG_BYTES * BW);

   localparam logic [BW-1:0] CMD_IMG = BW'(1);
   localparam logic [BW-1:0] CMD_KER = BW'(2);

   typedef enum logic [2:0] {
      IDLE,
      IMG_PAY,
      EMIT_IMG,
      KER_ADDR,
      KER_PAY,
      KER_VAL,
      EMIT_KER
   } state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic [IADDR_W-1:0]       slot;
   logic                     accept_state;
   logic                     beat;
   logic                     img_last;
   logic                     ker_last;

   // Shadow copies that accumulate a frame; outputs only change when a frame
   // completes, so an aborted partial frame never disturbs them.
   logic [IMG_BYTES*BW-1:0]  img_shadow;
   logic [IMG_BYTES*BW-1:0]  img_wr;
   logic [IMG_IW-1:0]        img_base;
   logic [KER_BITS-1:0]      ker_shadow;
   logic [KADDR_W-1:0]       addr_shadow;

   // Ready is a pure function of the registered state, held low during reset.
   assign accept_state = (state != EMIT_IMG) && (state != EMIT_KER);
   assign s_ready      = accept_state && !rst;
   assign beat         = s_valid && s_ready;

   assign img_last = (cnt == CNT_W'(IMG_BYTES - 1));
   assign ker_last = (cnt == CNT_W'(KER_BYTES - 1));
   assign img_base = IMG_IW'(cnt) * IMG_IW'(BW);

   // Image word with the current byte merged in, so the last payload beat can
   // load the output register directly and the strobe follows one cycle later.
   always_comb begin
      img_wr                 = img_shadow;
      img_wr[img_base +: BW] = s_data;
   end

   // ---------------------------------------------------------------- FSM
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt    = state;
      image_in_en  = 1'b0;
      kernel_in_en = 1'b0;
      unique case (state)
         IDLE: begin
            if (beat) begin
               if (s_data == CMD_IMG)      state_nxt = IMG_PAY;
               else if (s_data == CMD_KER) state_nxt = KER_ADDR;
            end
         end
         IMG_PAY:  if (beat && img_last) state_nxt = EMIT_IMG;
         EMIT_IMG: begin
            image_in_en = 1'b1;
            state_nxt   = IDLE;
         end
         KER_ADDR: if (beat) state_nxt = KER_PAY;
         KER_PAY:  if (beat && ker_last) state_nxt = KER_VAL;
         KER_VAL:  if (beat) state_nxt = EMIT_KER;
         EMIT_KER: begin
            kernel_in_en = 1'b1;
            state_nxt    = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------ counters and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         slot         <= '0;
         cmd_err      <= 1'b0;
         image        <= '0;
         image_addr   <= '0;
         kernel       <= '0;
         kernel_value <= '0;
         kernel_addr  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (beat) begin
                  cnt <= '0;
                  if (s_data != CMD_IMG && s_data != CMD_KER) cmd_err <= 1'b1;
               end
            end
            IMG_PAY: begin
               if (beat) begin
                  cnt <= cnt + 1'b1;
                  if (img_last) begin
                     image      <= img_wr[IMG_BITS-1:0];
                     image_addr <= slot;
                  end
               end
            end
            EMIT_IMG: slot <= slot + 1'b1;
            KER_ADDR: if (beat) cnt <= '0;
            KER_PAY:  if (beat) cnt <= cnt + 1'b1;
            KER_VAL: begin
               if (beat) begin
                  kernel       <= ker_shadow;
                  kernel_value <= s_data;
                  kernel_addr  <= addr_shadow;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------ shadow storage
   // NOTE: the shadows carry no reset: every bit is rewritten by a complete
   // frame before it reaches an output, so clearing them buys nothing.
   always_ff @(posedge clk) begin
      if (state == IMG_PAY && beat) img_shadow <= img_wr;
      if (state == KER_ADDR && beat) addr_shadow <= s_data[KADDR_W-1:0];
      if (state == KER_PAY && beat) begin
         // Bits beyond KER_BITS in the final kernel byte are dropped.
         for (int b = 0; b < KER_BITS; b++) begin
            if (b / BW == int'(cnt)) ker_shadow[b] <= s_data[b % BW];
         end
      end
   end

endmodule
